slot_bitmap_allocator: RTL and testbench

- Tracks WIDTH allocatable slots (ROB/issue-queue entries, physical registers) as a registered busy bitmap.
- Alloc side: finds the lowest free slot (bitmask -> index).
- Free side: the reverse direction, decoding a returned index to a one-hot clear of the bitmap.
- Provides a flush path, occupancy count and sticky protocol-error flag; sits between rename/dispatch (allocator) and commit/writeback (releaser).

---
 rtl/slot_bitmap_allocator_pkg.sv | 14 +
 rtl/priority_finder.sv | 32 +++
 rtl/slot_bitmap_allocator.sv | 103 ++++++++++
 tb/tb_slot_bitmap_allocator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/slot_bitmap_allocator_pkg.sv
// Shared types for the slot bitmap allocator and anything that sizes itself
// from the same slot count.
package slot_bitmap_allocator_pkg;

  localparam int unsigned SLOT_WIDTH_DEFAULT = 16;

  // Classification of the release request seen in one cycle.
  typedef enum logic [1:0] {
    FREE_NONE    = 2'd0,  // no release, or release masked by flush
    FREE_LEGAL   = 2'd1,  // in-range index of a busy slot
    FREE_ILLEGAL = 2'd2   // out of range or double free
  } free_kind_e;

endpackage : slot_bitmap_allocator_pkg

// File: rtl/priority_finder.sv
// Bitmask to index: reports whether any request bit is set and the index of
// the winning bit (lowest index when FIRST_PRIORITY=1, highest otherwise).
module priority_finder #(
  parameter int unsigned WIDTH          = 16,
  parameter bit          FIRST_PRIORITY = 1'b1,
  localparam int unsigned IDX_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  // Scan in priority order and latch onto the first set bit.
  always_comb begin
    // NOTE: every output gets a default before the loop so that no path
    // through this block leaves a value unassigned (which would infer a latch).
    valid_o = 1'b0;
    index_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!valid_o) begin
        if (FIRST_PRIORITY && req_i[i]) begin
          valid_o = 1'b1;
          index_o = IDX_W'(i);
        end else if (!FIRST_PRIORITY && req_i[WIDTH-1-i]) begin
          valid_o = 1'b1;
          index_o = IDX_W'(WIDTH-1-i);
        end
      end
    end
  end

endmodule : priority_finder

// File: rtl/slot_bitmap_allocator.sv
// Busy-bitmap slot allocator: same-cycle grant of the lowest free slot,
// one-hot release by index, flush to all-free, occupancy count and a sticky
// error flag for illegal releases (out of range or double free).
module slot_bitmap_allocator
  import slot_bitmap_allocator_pkg::*;
#(
  parameter int unsigned  WIDTH   = SLOT_WIDTH_DEFAULT,
  localparam int unsigned INDEX_W = $clog2(WIDTH),
  localparam int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_req_i,
  output logic               alloc_valid_o,
  output logic [INDEX_W-1:0] alloc_index_o,
  output logic               alloc_grant_o,
  input  logic               free_valid_i,
  input  logic [INDEX_W-1:0] free_index_i,
  input  logic               flush_i,
  output logic [CNT_W-1:0]   free_count_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               error_o
);

  logic [WIDTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] free_count_q, free_count_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] alloc_set;
  logic [WIDTH-1:0] free_clr;
  logic             free_in_range;
  free_kind_e       free_kind;

  // Lowest free slot is found on the inverted busy map.
  priority_finder #(
    .WIDTH         (WIDTH),
    .FIRST_PRIORITY(1'b1)
  ) u_free_finder (
    .req_i  (~busy_q),
    .valid_o(alloc_valid_o),
    .index_o(alloc_index_o)
  );

  assign alloc_grant_o = alloc_req_i && alloc_valid_o && !flush_i;

  // Zero-extend by one bit so the range check also works when WIDTH is a
  // power of two and every encodable index is legal.
  assign free_in_range = ({1'b0, free_index_i} < (INDEX_W + 1)'(WIDTH));

  // Classify the release and build the one-hot set/clear masks.
  always_comb begin
    free_kind = FREE_NONE;
    if (free_valid_i && !flush_i) begin
      if (free_in_range && busy_q[free_index_i]) free_kind = FREE_LEGAL;
      else                                       free_kind = FREE_ILLEGAL;
    end
    alloc_set = alloc_grant_o             ? (WIDTH'(1) << alloc_index_o) : '0;
    free_clr  = (free_kind == FREE_LEGAL) ? (WIDTH'(1) << free_index_i)  : '0;
  end

  // Next-state for bitmap, counter and sticky error; flush beats alloc/free.
  always_comb begin
    busy_d       = (busy_q | alloc_set) & ~free_clr;
    free_count_d = free_count_q;
    error_d      = error_q | (free_kind == FREE_ILLEGAL);
    if (flush_i) begin
      busy_d       = '0;
      free_count_d = CNT_W'(WIDTH);
    end else if (alloc_grant_o && (free_kind != FREE_LEGAL)) begin
      free_count_d = free_count_q - CNT_W'(1);
    end else if (!alloc_grant_o && (free_kind == FREE_LEGAL)) begin
      free_count_d = free_count_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset overriding all other activity.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      busy_q       <= '0;
      free_count_q <= CNT_W'(WIDTH);
      error_q      <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      free_count_q <= free_count_d;
      error_q      <= error_d;
    end
  end

  assign free_count_o = free_count_q;
  assign full_o       = (free_count_q == '0);
  assign empty_o      = (free_count_q == CNT_W'(WIDTH));
  assign error_o      = error_q;

  // The counter must always equal the number of clear bits in the bitmap.
  count_matches_bitmap : assert property (
    @(posedge clk) disable iff (rst)
      $countones(~busy_q) == int'(free_count_q)
  );

endmodule : slot_bitmap_allocator

// File: tb/tb_slot_bitmap_allocator.sv
// Self-checking bench: slot-array model compared every cycle, plus directed
// vectors with literal expectations for the WIDTH=4 scenarios.
module tb_slot_bitmap_allocator;

  localparam int W  = 4;
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic          alloc_valid;
  logic [IW-1:0] alloc_index;
  logic          alloc_grant;
  logic          free_valid;
  logic [IW-1:0] free_index;
  logic          flush;
  logic [CW-1:0] free_count;
  logic          full;
  logic          empty;
  logic          error;

  int n_checks = 0;
  int n_fail   = 0;

  slot_bitmap_allocator #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req_i  (alloc_req),
    .alloc_valid_o(alloc_valid),
    .alloc_index_o(alloc_index),
    .alloc_grant_o(alloc_grant),
    .free_valid_i (free_valid),
    .free_index_i (free_index),
    .flush_i      (flush),
    .free_count_o (free_count),
    .full_o       (full),
    .empty_o      (empty),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy [W];
  bit m_err;
  bit m_ok = 1'b0;

  function automatic int m_first_free();
    for (int i = 0; i < W; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int m_nfree();
    int n = 0;
    for (int i = 0; i < W; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    int ff;
    bit do_grant;
    bit do_free;
    if (rst) begin
      for (int i = 0; i < W; i++) m_busy[i] = 1'b0;
      m_err = 1'b0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      if (flush) begin
        for (int i = 0; i < W; i++) m_busy[i] = 1'b0;
      end else begin
        ff       = m_first_free();
        do_grant = alloc_req && (ff >= 0);
        do_free  = 1'b0;
        if (free_valid) begin
          if (int'(free_index) < W && m_busy[free_index]) do_free = 1'b1;
          else m_err = 1'b1;
        end
        if (do_free)  m_busy[free_index] = 1'b0;
        if (do_grant) m_busy[ff] = 1'b1;
      end
    end
  end

  // Compare DUT outputs against the model mid-cycle, away from the edge.
  always @(negedge clk) begin
    int ff;
    int nf;
    if (m_ok) begin
      ff = m_first_free();
      nf = m_nfree();
      check("m_alloc_valid", alloc_valid, (ff >= 0));
      if (ff >= 0) check("m_alloc_index", alloc_index, ff);
      check("m_alloc_grant", alloc_grant, alloc_req && (ff >= 0) && !flush);
      check("m_free_count", free_count, nf);
      check("m_full", full, (nf == 0));
      check("m_empty", empty, (nf == W));
      check("m_error", error, m_err);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit req, input bit fv, input int fi, input bit fl);
    alloc_req  = req;
    free_valid = fv;
    free_index = IW'(fi);
    flush      = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_free_count", free_count, 4);
    check("rst_alloc_valid", alloc_valid, 1);
    check("rst_alloc_index", alloc_index, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_error", error, 0);

    // Fill all four slots in order.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      check("fill_grant", alloc_grant, 1);
      check("fill_index", alloc_index, i);
      check("fill_count", free_count, 4 - i);
      tick();
    end
    check("full_flag", full, 1);
    check("full_alloc_valid", alloc_valid, 0);
    check("full_grant", alloc_grant, 0);
    check("full_count", free_count, 0);

    // Release slot 2, then slot 0.
    drive(0, 1, 2, 0);
    tick();
    check("free2_index", alloc_index, 2);
    check("free2_count", free_count, 1);
    drive(0, 1, 0, 0);
    tick();
    check("free0_index", alloc_index, 0);
    check("free0_count", free_count, 2);

    // busy=1010: alloc slot 0 -> 1011; alloc 2 + free 3 -> 0111.
    drive(1, 0, 0, 0);
    tick();
    drive(1, 1, 3, 0);
    check("swap_grant_index", alloc_index, 2);
    tick();
    check("b0111_count", free_count, 1);
    check("b0111_index", alloc_index, 3);

    // Same-cycle alloc of 3 and free of 1 -> busy=1101.
    drive(1, 1, 1, 0);
    check("both_grant", alloc_grant, 1);
    check("both_index", alloc_index, 3);
    tick();
    check("both_count", free_count, 1);
    check("both_next_index", alloc_index, 1);

    // Double free of slot 1.
    drive(0, 1, 1, 0);
    tick();
    check("dfree_error", error, 1);
    check("dfree_count", free_count, 1);
    check("dfree_index", alloc_index, 1);

    // busy=1101: alloc 1 -> 1111, free 2 -> 1011.
    drive(1, 0, 0, 0);
    tick();
    check("refill_full", full, 1);
    drive(0, 1, 2, 0);
    tick();
    check("b1011_count", free_count, 1);

    // Flush with simultaneous alloc and free.
    drive(1, 1, 0, 1);
    check("flush_grant", alloc_grant, 0);
    tick();
    drive(0, 0, 0, 0);
    check("flush_count", free_count, 4);
    check("flush_empty", empty, 1);
    check("flush_index", alloc_index, 0);
    check("flush_keeps_error", error, 1);

    // Build busy=0011 then reset while requesting.
    drive(1, 0, 0, 0);
    tick();
    tick();
    check("b0011_count", free_count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    check("rst2_count", free_count, 4);
    check("rst2_error", error, 0);
    check("rst2_index", alloc_index, 0);

    // Short mixed sequence checked only by the model.
    for (int i = 0; i < 24; i++) begin
      drive(i % 3 != 2, i % 2 == 1, (i * 3) % 4, i == 17);
      tick();
    end
    drive(0, 0, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_slot_bitmap_allocator
